// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive buffer controller: controller states
// and receiver timing constants.
package uart_pkg;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        RUN      = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    localparam int UART_CLKS_PER_BIT = 434;
    localparam int UART_HALF_BIT     = 217;
    localparam int DROP_CNT_W        = 16;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head output, an occupancy count and a
// synchronous clear that discards the contents.
module sync_fifo #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (wr_en && !clear) begin
            mem[wr_ptr] <= din;
        end
    end

    assign dout = mem[rd_ptr];

    // Pointers are exactly log2(DEPTH) bits, so they wrap without compare logic.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_buffer_ctrl.sv
// Sits between the UART byte receiver and the CPU: gates the receiver, buffers
// bytes, serves CPU reads and reports overrun, drop count and line-idle events.
module uart_rx_buffer_ctrl
    import uart_pkg::*;
#(
    parameter  int DEPTH       = 16,
    parameter  int IDLE_CYCLES = 4340,
    localparam int CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  flush,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_hold,
    input  logic                  rd_req,
    output logic [7:0]            rd_data,
    output logic                  rd_valid,
    output logic [CNT_W-1:0]      count,
    output logic                  empty,
    output logic                  full,
    output logic                  overrun,
    input  logic                  overrun_clr,
    output logic [DROP_CNT_W-1:0] drop_count,
    output logic                  idle_pulse
);

    localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);

    state_t            state;
    state_t            state_nxt;
    logic              rd_en;
    logic              wr_en;
    logic              drop;
    logic [7:0]        fifo_dout;
    logic              idle_armed;
    logic [IDLE_W-1:0] idle_cnt;

    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

    assign state_nxt = flush ? FLUSH : (enable ? RUN : DISABLED);

    // A flush pulse discards everything, so it also suppresses same-cycle traffic.
    assign rd_en = rd_req && !empty && (state != FLUSH) && !flush;
    assign wr_en = (state == RUN) && !flush && rx_valid && (!full || rd_en);
    assign drop  = (state == RUN) && !flush && rx_valid && full && !rd_en;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .wr_en (wr_en),
        .din   (rx_data),
        .rd_en (rd_en),
        .dout  (fifo_dout),
        .count (count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= DISABLED;
            rx_hold <= 1'b1;
        end else begin
            state   <= state_nxt;
            rx_hold <= (state_nxt != RUN);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= fifo_dout;
            end
        end
    end

    // Drop sets overrun even when a clear arrives in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun    <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overrun    <= 1'b1;
            drop_count <= sat_inc(drop_count);
        end else if (overrun_clr) begin
            overrun    <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_armed <= 1'b0;
            idle_cnt   <= '0;
            idle_pulse <= 1'b0;
        end else if (state_nxt != RUN) begin
            idle_armed <= 1'b0;
            idle_cnt   <= '0;
            idle_pulse <= 1'b0;
        end else if (wr_en) begin
            idle_armed <= 1'b1;
            idle_cnt   <= '0;
            idle_pulse <= 1'b0;
        end else if (idle_armed && (state == RUN)) begin
            if (idle_cnt == IDLE_W'(IDLE_CYCLES - 1)) begin
                idle_armed <= 1'b0;
                idle_cnt   <= '0;
                idle_pulse <= 1'b1;
            end else begin
                idle_cnt   <= idle_cnt + 1'b1;
                idle_pulse <= 1'b0;
            end
        end else begin
            idle_pulse <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_buffer_ctrl.sv
// Directed bench for uart_rx_buffer_ctrl: a per-cycle vector table followed by
// hand-written overflow, idle-timer, flush, disable and reset sequences.
module tb_uart_rx_buffer_ctrl;

    localparam int DEPTH = 16;
    localparam int IDLE  = 20;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          flush;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rx_hold;
    logic          rd_req;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          overrun;
    logic          overrun_clr;
    logic [15:0]   drop_count;
    logic          idle_pulse;

    int n_vec = 0;
    int n_err = 0;

    uart_rx_buffer_ctrl #(
        .DEPTH       (DEPTH),
        .IDLE_CYCLES (IDLE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .flush       (flush),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_hold     (rx_hold),
        .rd_req      (rd_req),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .overrun     (overrun),
        .overrun_clr (overrun_clr),
        .drop_count  (drop_count),
        .idle_pulse  (idle_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       fl;
        logic       rv;
        logic [7:0] din;
        logic       rq;
        logic       oc;
        int         cnt;
        logic       vld;
        logic [7:0] dat;
        logic       hold;
        logic       ovr;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic step(input logic en, input logic fl, input logic rv, input logic [7:0] d,
                        input logic rq, input logic oc);
        enable      = en;
        flush       = fl;
        rx_valid    = rv;
        rx_data     = d;
        rd_req      = rq;
        overrun_clr = oc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        step(0, 0, 0, 8'h00, 0, 0);
        step(0, 0, 0, 8'h00, 0, 0);
        chk("reset_hold", 32'(rx_hold), 32'd1);
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_empty", 32'(empty), 32'd1);
        chk("reset_full", 32'(full), 32'd0);
        chk("reset_rd_valid", 32'(rd_valid), 32'd0);
        chk("reset_rd_data", 32'(rd_data), 32'd0);
        chk("reset_drop", 32'(drop_count), 32'd0);
        reset = 1'b1;

        //          en fl rv din    rq oc  cnt vld dat    hold ovr
        tbl[0]  = '{1, 0, 1, 8'h99, 0, 0,  0,  0,  8'h00, 0,   0};
        tbl[1]  = '{1, 0, 1, 8'h41, 0, 0,  1,  0,  8'h00, 0,   0};
        tbl[2]  = '{1, 0, 1, 8'h42, 0, 0,  2,  0,  8'h00, 0,   0};
        tbl[3]  = '{1, 0, 1, 8'h43, 0, 0,  3,  0,  8'h00, 0,   0};
        tbl[4]  = '{1, 0, 0, 8'h00, 1, 0,  2,  1,  8'h41, 0,   0};
        tbl[5]  = '{1, 0, 0, 8'h00, 0, 0,  2,  0,  8'h00, 0,   0};
        tbl[6]  = '{1, 0, 0, 8'h00, 1, 0,  1,  1,  8'h42, 0,   0};
        tbl[7]  = '{1, 0, 0, 8'h00, 0, 0,  1,  0,  8'h00, 0,   0};
        tbl[8]  = '{1, 0, 0, 8'h00, 1, 0,  0,  1,  8'h43, 0,   0};
        tbl[9]  = '{1, 0, 0, 8'h00, 1, 0,  0,  0,  8'h00, 0,   0};
        tbl[10] = '{0, 0, 0, 8'h00, 0, 0,  0,  0,  8'h00, 1,   0};
        tbl[11] = '{0, 0, 1, 8'h55, 0, 0,  0,  0,  8'h00, 1,   0};
        tbl[12] = '{1, 0, 0, 8'h00, 0, 0,  0,  0,  8'h00, 0,   0};
        tbl[13] = '{1, 0, 1, 8'h60, 1, 0,  1,  0,  8'h00, 0,   0};
        tbl[14] = '{1, 0, 0, 8'h00, 1, 0,  0,  1,  8'h60, 0,   0};
        tbl[15] = '{0, 0, 0, 8'h00, 0, 0,  0,  0,  8'h00, 1,   0};

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].en, tbl[i].fl, tbl[i].rv, tbl[i].din, tbl[i].rq, tbl[i].oc);
            chk($sformatf("v%0d_count", i), 32'(count), 32'(tbl[i].cnt));
            chk($sformatf("v%0d_rd_valid", i), 32'(rd_valid), 32'(tbl[i].vld));
            if (tbl[i].vld) chk($sformatf("v%0d_rd_data", i), 32'(rd_data), 32'(tbl[i].dat));
            chk($sformatf("v%0d_rx_hold", i), 32'(rx_hold), 32'(tbl[i].hold));
            chk($sformatf("v%0d_overrun", i), 32'(overrun), 32'(tbl[i].ovr));
            chk($sformatf("v%0d_idle", i), 32'(idle_pulse), 32'd0);
        end
        chk("tbl_empty_after", 32'(empty), 32'd1);

        // Overflow: 18 pushes into 16 entries.
        step(1, 0, 0, 8'h00, 0, 0);
        for (int i = 0; i < 18; i++) step(1, 0, 1, 8'(8'h10 + i), 0, 0);
        chk("ovf_count", 32'(count), 32'd16);
        chk("ovf_full", 32'(full), 32'd1);
        chk("ovf_overrun", 32'(overrun), 32'd1);
        chk("ovf_drop", 32'(drop_count), 32'd2);
        step(1, 0, 0, 8'h00, 0, 1);
        chk("clr_overrun", 32'(overrun), 32'd0);
        chk("clr_drop_kept", 32'(drop_count), 32'd2);
        step(1, 0, 1, 8'hEE, 1, 0);
        chk("fullrw_count", 32'(count), 32'd16);
        chk("fullrw_valid", 32'(rd_valid), 32'd1);
        chk("fullrw_data", 32'(rd_data), 32'h10);
        chk("fullrw_drop", 32'(drop_count), 32'd2);
        chk("fullrw_overrun", 32'(overrun), 32'd0);
        step(1, 0, 1, 8'hEF, 0, 1);
        chk("setwins_overrun", 32'(overrun), 32'd1);
        chk("setwins_drop", 32'(drop_count), 32'd3);
        chk("setwins_count", 32'(count), 32'd16);
        for (int i = 0; i < 16; i++) begin
            step(1, 0, 0, 8'h00, 1, 0);
            chk($sformatf("drain%0d_valid", i), 32'(rd_valid), 32'd1);
            chk($sformatf("drain%0d_data", i), 32'(rd_data), (i < 15) ? 32'(8'h11 + i) : 32'hEE);
        end
        chk("drain_empty", 32'(empty), 32'd1);
        step(1, 0, 0, 8'h00, 1, 0);
        chk("drain_extra_rd", 32'(rd_valid), 32'd0);
        step(0, 0, 0, 8'h00, 0, 0);

        // Idle timer: pulse exactly IDLE cycles after the last accepted write.
        step(1, 0, 0, 8'h00, 0, 0);
        step(1, 0, 1, 8'hA0, 0, 0);
        for (int k = 1; k <= IDLE + 4; k++) begin
            step(1, 0, 0, 8'h00, 0, 0);
            chk($sformatf("idle1_k%0d", k), 32'(idle_pulse), (k == IDLE) ? 32'd1 : 32'd0);
        end
        step(1, 0, 1, 8'hA1, 0, 0);
        for (int k = 1; k <= IDLE - 3; k++) begin
            step(1, 0, 0, 8'h00, 0, 0);
            chk($sformatf("idle2_k%0d", k), 32'(idle_pulse), 32'd0);
        end
        step(1, 0, 1, 8'hA2, 0, 0);
        chk("idle2_restart", 32'(idle_pulse), 32'd0);
        for (int k = 1; k <= IDLE + 3; k++) begin
            step(1, 0, 0, 8'h00, 0, 0);
            chk($sformatf("idle3_k%0d", k), 32'(idle_pulse), (k == IDLE) ? 32'd1 : 32'd0);
        end
        chk("idle_count", 32'(count), 32'd3);

        // Flush with 5 bytes held while enabled.
        step(1, 0, 1, 8'hB0, 0, 0);
        step(1, 0, 1, 8'hB1, 0, 0);
        chk("preflush_count", 32'(count), 32'd5);
        step(1, 1, 0, 8'h00, 0, 0);
        chk("flush_hold", 32'(rx_hold), 32'd1);
        chk("flush_count", 32'(count), 32'd0);
        step(1, 0, 1, 8'h77, 1, 0);
        chk("postflush_hold", 32'(rx_hold), 32'd0);
        chk("postflush_count", 32'(count), 32'd0);
        chk("postflush_valid", 32'(rd_valid), 32'd0);
        chk("flush_keeps_overrun", 32'(overrun), 32'd1);
        chk("flush_keeps_drop", 32'(drop_count), 32'd3);
        step(1, 0, 0, 8'h00, 0, 1);
        chk("clr2_overrun", 32'(overrun), 32'd0);

        // Disabled: receiver held, input ignored, buffered bytes still readable.
        step(1, 0, 1, 8'h31, 0, 0);
        step(1, 0, 1, 8'h32, 0, 0);
        step(0, 0, 0, 8'h00, 0, 0);
        chk("dis_hold", 32'(rx_hold), 32'd1);
        step(0, 0, 1, 8'h33, 0, 0);
        chk("dis_ignore_count", 32'(count), 32'd2);
        chk("dis_no_overrun", 32'(overrun), 32'd0);
        step(0, 0, 0, 8'h00, 1, 0);
        chk("dis_rd1_valid", 32'(rd_valid), 32'd1);
        chk("dis_rd1_data", 32'(rd_data), 32'h31);
        step(0, 0, 0, 8'h00, 1, 0);
        chk("dis_rd2_data", 32'(rd_data), 32'h32);
        chk("dis_rd2_count", 32'(count), 32'd0);

        // Asynchronous reset in the middle of a cycle with the FIFO full and overrun set.
        step(1, 0, 0, 8'h00, 0, 0);
        for (int i = 0; i < 17; i++) step(1, 0, 1, 8'(8'hC0 + i), 0, 0);
        chk("prerst_drop", 32'(drop_count), 32'd4);
        chk("prerst_overrun", 32'(overrun), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_hold", 32'(rx_hold), 32'd1);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_overrun", 32'(overrun), 32'd0);
        chk("arst_drop", 32'(drop_count), 32'd0);
        chk("arst_rd_data", 32'(rd_data), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        step(0, 0, 0, 8'h00, 0, 0);
        chk("after_rst_hold", 32'(rx_hold), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_buffer_ctrl.md
Name: uart_rx_buffer_ctrl

Overview:
Controller between the UART byte receiver and the CPU. It enables, holds or flushes the receiver and buffers completed bytes in a FIFO. It presents the bytes to the CPU through a read-request handshake. It also reports overrun, dropped-byte count and end-of-message (line idle) events, so the CPU no longer has to catch single-cycle completion pulses.

Parameters:
DEPTH, 16, FIFO entries; power of two, 2..256
IDLE_CYCLES, 4340, clk cycles with no new byte before idle_pulse (10 bit times at 434 clk/bit)
CNT_W, $clog2(DEPTH+1), width of count output (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset; 0 = reset asserted
enable  in  1  level; 1 = accept bytes from receiver
flush  in  1  single-cycle pulse; discard FIFO contents
rx_valid  in  1  receiver byte-complete pulse, 1 cycle
rx_data  in  8  receiver byte, valid with rx_valid
rx_hold  out  1  drives receiver's reset; 1 = hold receiver idle
rd_req  in  1  CPU read request, 1 cycle
rd_data  out  8  byte read, valid when rd_valid=1
rd_valid  out  1  1-cycle pulse, one cycle after accepted rd_req
count  out  CNT_W  bytes currently held
empty  out  1  count==0
full  out  1  count==DEPTH
overrun  out  1  sticky: byte dropped because FIFO full
overrun_clr  in  1  pulse; clears overrun
drop_count  out  16  dropped bytes, saturates at 16'hFFFF
idle_pulse  out  1  1-cycle end-of-message strobe

Behaviour:
- Reset (reset==0, async): state DISABLED, pointers/count 0, rd_data 0, rd_valid 0, overrun 0, drop_count 0, idle counter 0, idle_pulse 0, rx_hold 1.
- States and transitions:
  - DISABLED -> RUN when enable=1.
  - RUN -> DISABLED when enable=0.
  - Any state -> FLUSH on flush=1; flush has priority over enable.
  - FLUSH is exactly 1 cycle, then RUN if enable else DISABLED.
- rx_hold is 1 in DISABLED and FLUSH, 0 in RUN, registered. A byte mid-frame is abandoned when the block leaves RUN.
- Write: in RUN, rx_valid && !full stores rx_data. rx_valid in DISABLED or FLUSH is ignored and is not an overrun.
- Overrun: in RUN, rx_valid && full && !rd_req drops the byte, sets overrun=1 and increments drop_count (saturating).
- Full plus read: rx_valid && full && rd_req performs both the read and the write; nothing is dropped; count unchanged.
- Read: rd_req && !empty pops the head. rd_data and rd_valid are registered 1 cycle later. rd_req when empty is ignored (rd_valid stays 0). There is no empty bypass: a write and a read in the same cycle on an empty FIFO returns nothing. Reads are allowed in DISABLED. A rd_req in the FLUSH cycle is ignored.
- rd_data holds its last value when rd_valid=0.
- Pointers are log2(DEPTH) bits and wrap naturally. count is updated +1/-1/0 per cycle.
- Flush: pointers, count and idle counter are set to 0. overrun and drop_count are kept.
- overrun_clr clears overrun. If overrun_clr and a new drop occur in the same cycle, set wins.
- Idle counter:
  - Armed on each accepted write; reloads to 0 on every accepted write.
  - While armed in RUN, counts up each cycle.
  - When it reaches IDLE_CYCLES-1 it fires idle_pulse for 1 cycle and disarms.
  - Disarmed on leaving RUN; no pulse is fired then.
  - Dropped bytes do not re-arm it.
- empty and full are derived combinationally from count.

Decomposition:
- Shared package uart_pkg: state enum (DISABLED, RUN, FLUSH), UART_CLKS_PER_BIT=434, UART_HALF_BIT=217, DROP_CNT_W=16.
- One natural sub-module: sync_fifo (DEPTH, WIDTH=8; wr_en, rd_en, dout, count). The FSM, overrun, idle timer and read-register logic stay in uart_rx_buffer_ctrl.

Test Plan:
- Reset low mid-operation with 3 bytes held -> outputs immediately at reset values; rx_hold=1, count=0, overrun=0.
- enable=1, push 0x41,0x42,0x43, then 3 rd_req pulses spaced 2 cycles -> rd_valid pulses carry 0x41,0x42,0x43 one cycle after each request; empty=1 afterwards; extra rd_req gives no rd_valid.
- DEPTH=16: push 18 bytes with no reads -> full=1, count=16, overrun=1, drop_count=2, first 16 bytes read back in order. Then overrun_clr -> overrun=0, drop_count stays 2.
- Full FIFO, rx_valid and rd_req in same cycle -> no drop, count stays 16, rd_data = oldest byte; overrun_clr coincident with a drop -> overrun stays 1.
- Push 1 byte, stay quiet -> idle_pulse exactly IDLE_CYCLES cycles after the write, once only. A byte arriving at IDLE_CYCLES-2 restarts the count.
- flush with 5 bytes held while enable=1 -> one cycle rx_hold=1, count=0, back to RUN. rx_valid during the FLUSH cycle is not stored. enable=0 -> rx_hold=1, rx_valid ignored, buffered bytes still readable.
